// File: rtl/btn_step_repeat_if.sv
// Button step/repeat bus: debounced level and enable in, event pulses and status out.
//   btn_level     : debounced button level, 1 = pressed
//   enable        : 1 = block active, 0 = forced idle
//   press_pulse   : one-cycle pulse on a new press
//   step_pulse    : one-cycle pulse on a press and on every auto-repeat
//   release_pulse : one-cycle pulse on release of an accepted press
//   held          : high during the repeat phase
//   repeat_count  : repeat steps in the current press, saturating
interface btn_step_repeat_if;
  logic       btn_level;
  logic       enable;
  logic       press_pulse;
  logic       step_pulse;
  logic       release_pulse;
  logic       held;
  logic [7:0] repeat_count;

  modport master (
    output btn_level, enable,
    input  press_pulse, step_pulse, release_pulse, held, repeat_count
  );

  modport slave (
    input  btn_level, enable,
    output press_pulse, step_pulse, release_pulse, held, repeat_count
  );
endinterface

// File: rtl/btn_step_repeat.sv
// Converts a debounced button level into press/step/release pulses with
// auto-repeat after a hold delay, a long-press flag and a repeat counter.
//   clk : system clock
//   rst : synchronous active-low reset
//   bus : btn_step_repeat_if slave (level/enable in, pulses/status out)
module btn_step_repeat #(
  parameter int unsigned DELAY_CYCLES = 25000000,
  parameter int unsigned RATE_CYCLES  = 5000000,
  parameter int unsigned CNT_W        = 25
) (
  input  logic              clk,
  input  logic              rst,
  btn_step_repeat_if.slave  bus
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_WAIT   = 2'd1;
  localparam logic [1:0] S_REPEAT = 2'd2;

  localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(DELAY_CYCLES - 1);
  localparam logic [CNT_W-1:0] RATE_LAST  = CNT_W'(RATE_CYCLES - 1);

  logic [1:0]       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             btn_prev;
  logic             press_q, press_nxt;
  logic             step_q, step_nxt;
  logic             release_q, release_nxt;
  logic             held_q, held_nxt;
  logic [7:0]       rc_q, rc_nxt;
  logic [7:0]       rc_inc;
  logic             rise;

  assign rise   = bus.btn_level & ~btn_prev;
  assign rc_inc = (rc_q == 8'hFF) ? rc_q : rc_q + 8'd1;

  // Next state and next registered outputs; release beats terminal count,
  // enable=0 beats everything (no release for an aborted press).
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    press_nxt   = 1'b0;
    step_nxt    = 1'b0;
    release_nxt = 1'b0;
    held_nxt    = held_q;
    rc_nxt      = rc_q;

    if (!bus.enable) begin
      state_nxt = S_IDLE;
      cnt_nxt   = '0;
      held_nxt  = 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          held_nxt = 1'b0;
          if (rise) begin
            press_nxt = 1'b1;
            step_nxt  = 1'b1;
            rc_nxt    = 8'd0;
            cnt_nxt   = '0;
            state_nxt = S_WAIT;
          end
        end
        S_WAIT: begin
          if (!bus.btn_level) begin
            release_nxt = 1'b1;
            cnt_nxt     = '0;
            state_nxt   = S_IDLE;
          end else if (cnt == DELAY_LAST) begin
            step_nxt  = 1'b1;
            held_nxt  = 1'b1;
            rc_nxt    = rc_inc;
            cnt_nxt   = '0;
            state_nxt = S_REPEAT;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
        S_REPEAT: begin
          if (!bus.btn_level) begin
            release_nxt = 1'b1;
            held_nxt    = 1'b0;
            cnt_nxt     = '0;
            state_nxt   = S_IDLE;
          end else if (cnt == RATE_LAST) begin
            step_nxt = 1'b1;
            rc_nxt   = rc_inc;
            cnt_nxt  = '0;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
        default: begin
          state_nxt = S_IDLE;
          cnt_nxt   = '0;
          held_nxt  = 1'b0;
        end
      endcase
    end
  end

  // State and output registers; btn_prev resets high so a button held
  // through reset is not taken as a press.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      btn_prev  <= 1'b1;
      press_q   <= 1'b0;
      step_q    <= 1'b0;
      release_q <= 1'b0;
      held_q    <= 1'b0;
      rc_q      <= 8'd0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      btn_prev  <= bus.btn_level;
      press_q   <= press_nxt;
      step_q    <= step_nxt;
      release_q <= release_nxt;
      held_q    <= held_nxt;
      rc_q      <= rc_nxt;
    end
  end

  assign bus.press_pulse   = press_q;
  assign bus.step_pulse    = step_q;
  assign bus.release_pulse = release_q;
  assign bus.held          = held_q;
  assign bus.repeat_count  = rc_q;

endmodule

// File: tb/tb_btn_step_repeat.sv
// Directed bench for btn_step_repeat: expected pulse events are queued as
// stimulus is driven and matched against the DUT pulses as they appear.
module tb_btn_step_repeat;

  localparam int DLY   = 8;
  localparam int RT_A  = 4;
  localparam int RT_B  = 2;

  logic clk;
  logic rst;
  int   cyc;
  int   n_assert;
  int   n_fail;
  bit   mon_on;

  typedef struct {
    int         cyc;
    logic [2:0] bits;  // {press, step, release}
  } ev_t;

  ev_t exp_q[$];

  btn_step_repeat_if ifa ();
  btn_step_repeat_if ifb ();

  btn_step_repeat #(.DELAY_CYCLES(DLY), .RATE_CYCLES(RT_A), .CNT_W(4)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (ifa.slave)
  );

  btn_step_repeat #(.DELAY_CYCLES(DLY), .RATE_CYCLES(RT_B), .CNT_W(4)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (ifb.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input logic [2:0] bits, input int c);
    ev_t e;
    e.cyc  = c;
    e.bits = bits;
    exp_q.push_back(e);
  endtask

  // Every pulse seen on DUT A must match the next queued expectation.
  always @(negedge clk) begin : monitor
    logic [2:0] obs;
    ev_t        e;
    if (mon_on) begin
      obs = {ifa.press_pulse, ifa.step_pulse, ifa.release_pulse};
      if (obs !== 3'b000) begin
        if (exp_q.size() == 0) begin
          check("unexpected_pulse", 32'(obs), 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("pulse_cycle", 32'(cyc), 32'(e.cyc));
          check("pulse_kind", 32'(obs), 32'(e.bits));
        end
      end
    end
  end

  initial begin
    int p;
    int exp_rc;
    logic exp_step;
    n_assert = 0;
    n_fail   = 0;
    mon_on   = 1'b0;
    rst      = 1'b0;
    ifa.btn_level = 1'b0;
    ifa.enable    = 1'b1;
    ifb.btn_level = 1'b0;
    ifb.enable    = 1'b1;

    // Reset values
    step(3);
    check("rst_press", 32'(ifa.press_pulse), 32'd0);
    check("rst_step", 32'(ifa.step_pulse), 32'd0);
    check("rst_release", 32'(ifa.release_pulse), 32'd0);
    check("rst_held", 32'(ifa.held), 32'd0);
    check("rst_count", 32'(ifa.repeat_count), 32'd0);
    rst = 1'b1;
    step(2);
    mon_on = 1'b1;

    // Short press
    p = cyc + 1;
    push(3'b110, p);
    push(3'b001, p + 3);
    ifa.btn_level = 1'b1;
    step(2);
    check("short_held", 32'(ifa.held), 32'd0);
    step(1);
    ifa.btn_level = 1'b0;
    step(1);
    check("short_count", 32'(ifa.repeat_count), 32'd0);
    check("short_held_after", 32'(ifa.held), 32'd0);
    step(2);
    check("short_missed", 32'(exp_q.size()), 32'd0);

    // Long hold: 30 cycles
    p = cyc + 1;
    push(3'b110, p);
    push(3'b010, p + DLY);
    for (int k = 1; k <= 5; k++) push(3'b010, p + DLY + k * RT_A);
    push(3'b001, p + 30);
    ifa.btn_level = 1'b1;
    step(7);
    check("long_held_early", 32'(ifa.held), 32'd0);
    step(2);
    check("long_held_on", 32'(ifa.held), 32'd1);
    check("long_count_1", 32'(ifa.repeat_count), 32'd1);
    step(21);
    check("long_count_6", 32'(ifa.repeat_count), 32'd6);
    ifa.btn_level = 1'b0;
    step(1);
    check("long_held_off", 32'(ifa.held), 32'd0);
    check("long_count_rel", 32'(ifa.repeat_count), 32'd6);
    step(2);
    check("long_missed", 32'(exp_q.size()), 32'd0);

    // Release sampled on the terminal-count edge in REPEAT
    p = cyc + 1;
    push(3'b110, p);
    push(3'b010, p + DLY);
    push(3'b001, p + DLY + RT_A);
    ifa.btn_level = 1'b1;
    step(DLY + RT_A);
    ifa.btn_level = 1'b0;
    step(1);
    check("coinc_count", 32'(ifa.repeat_count), 32'd1);
    check("coinc_held", 32'(ifa.held), 32'd0);
    step(2);
    check("coinc_missed", 32'(exp_q.size()), 32'd0);

    // enable dropped in REPEAT, raised while held, then re-press
    p = cyc + 1;
    push(3'b110, p);
    push(3'b010, p + DLY);
    ifa.btn_level = 1'b1;
    step(DLY + 2);
    ifa.enable = 1'b0;
    step(1);
    check("en_held_off", 32'(ifa.held), 32'd0);
    step(3);
    ifa.enable = 1'b1;
    step(5);
    check("en_held_still", 32'(ifa.held), 32'd0);
    check("en_count_hold", 32'(ifa.repeat_count), 32'd1);
    ifa.btn_level = 1'b0;
    step(2);
    check("en_missed", 32'(exp_q.size()), 32'd0);
    p = cyc + 1;
    push(3'b110, p);
    push(3'b001, p + 3);
    ifa.btn_level = 1'b1;
    step(3);
    ifa.btn_level = 1'b0;
    step(1);
    check("en_repress_count", 32'(ifa.repeat_count), 32'd0);
    step(2);
    check("en_repress_missed", 32'(exp_q.size()), 32'd0);

    // Reset during hold
    p = cyc + 1;
    push(3'b110, p);
    push(3'b010, p + DLY);
    ifa.btn_level = 1'b1;
    step(DLY + 2);
    rst = 1'b0;
    step(1);
    rst = 1'b1;
    check("mrst_press", 32'(ifa.press_pulse), 32'd0);
    check("mrst_step", 32'(ifa.step_pulse), 32'd0);
    check("mrst_release", 32'(ifa.release_pulse), 32'd0);
    check("mrst_held", 32'(ifa.held), 32'd0);
    check("mrst_count", 32'(ifa.repeat_count), 32'd0);
    step(5);
    ifa.btn_level = 1'b0;
    step(2);
    check("mrst_missed", 32'(exp_q.size()), 32'd0);
    p = cyc + 1;
    push(3'b110, p);
    push(3'b001, p + 3);
    ifa.btn_level = 1'b1;
    step(3);
    ifa.btn_level = 1'b0;
    step(3);
    check("mrst_repress_missed", 32'(exp_q.size()), 32'd0);

    // Saturation on DUT B (RATE_CYCLES=2), held 600 cycles
    ifb.btn_level = 1'b1;
    for (int i = 0; i < 600; i++) begin
      step(1);
      exp_step = (i == 0) || (i >= DLY && ((i - DLY) % RT_B) == 0);
      exp_rc   = (i < DLY) ? 0 : ((i - DLY) / RT_B + 1);
      if (exp_rc > 255) exp_rc = 255;
      check("sat_step", 32'(ifb.step_pulse), 32'(exp_step));
      check("sat_count", 32'(ifb.repeat_count), 32'(exp_rc));
    end
    ifb.btn_level = 1'b0;
    step(1);
    check("sat_release", 32'(ifb.release_pulse), 32'd1);
    check("sat_count_rel", 32'(ifb.repeat_count), 32'd255);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/btn_step_repeat.md
Name: btn_step_repeat

Overview:
- Downstream consumer of the push-button debouncer in the VGA board design.
- Takes one clean, active-high button level and converts it into one-clock event pulses: press, step (press plus auto-repeat) and release.
- Also exposes a long-press flag and a repeat counter.
- Feeds the cursor/colour-select logic so that one press moves one step and holding the button scrolls.

Parameters:
- DELAY_CYCLES, 25000000, cycles from the press step to the first repeat step (0.5 s at 50 MHz); legal range >= 2.
- RATE_CYCLES, 5000000, cycles between consecutive repeat steps (0.1 s at 50 MHz); legal range >= 2.
- CNT_W, 25, interval counter width; must hold max(DELAY_CYCLES, RATE_CYCLES) - 1.

Ports:
- clk  input  1  system clock; single clock domain.
- rst  input  1  reset, synchronous, active-low.
- btn_level  input  1  debounced button level, 1 = pressed; already synchronous to clk.
- enable  input  1  1 = block active; 0 = forced idle.
- press_pulse  output  1  one-cycle pulse on a new press.
- step_pulse  output  1  one-cycle pulse on a press and on every auto-repeat.
- release_pulse  output  1  one-cycle pulse on release of a press that this block accepted.
- held  output  1  high while in the repeat phase (long press).
- repeat_count  output  8  number of repeat steps in the current press; saturates at 255.

Behaviour:
- General: all outputs are registered. Internal state: FSM {IDLE, WAIT_DELAY, REPEAT}, CNT_W-bit counter, btn_prev register.
- Reset (rst=0 sampled at a clk edge):
  - state=IDLE, counter=0.
  - press_pulse=step_pulse=release_pulse=0, held=0, repeat_count=0.
  - btn_prev=1, so a button already held when reset deasserts produces no press.
- btn_prev: loads btn_level every non-reset cycle, regardless of enable or state.
- Pulse defaults: press_pulse, step_pulse and release_pulse are 0 every cycle unless asserted below. Each pulse lasts exactly one cycle.
- enable=0:
  - Next state is IDLE, counter=0, held=0, no pulses. repeat_count holds its value.
  - After enable returns to 1, a press needs a fresh rising edge (btn_level=1 with btn_prev=0).
- IDLE (enable=1):
  - On btn_level=1 and btn_prev=0: press_pulse=1, step_pulse=1, repeat_count=0, counter=0, go to WAIT_DELAY.
  - Latency: pulses are visible in the cycle after the first clk edge at which btn_level is sampled high.
- WAIT_DELAY:
  - If btn_level=0: release_pulse=1, go to IDLE, counter=0.
  - Else if counter==DELAY_CYCLES-1: step_pulse=1, held=1, repeat_count+1, counter=0, go to REPEAT.
  - Else: counter+1.
- REPEAT:
  - If btn_level=0: release_pulse=1, held=0, go to IDLE, counter=0.
  - Else if counter==RATE_CYCLES-1: step_pulse=1, repeat_count+1 (saturating at 255), counter=0.
  - Else: counter+1.
- Step timing: the first repeat step comes DELAY_CYCLES cycles after the press step. Later steps come every RATE_CYCLES cycles.
- Simultaneous events:
  - Release has priority over terminal count: no step_pulse in that cycle, only release_pulse.
  - enable=0 has priority over everything: no release_pulse is generated for a press aborted by enable.
- repeat_count: never wraps; it holds its value after release until the next accepted press clears it.
- press_pulse and release_pulse are never high in the same cycle.
- Reset mid-operation: same as the power-up reset values above. A button still held afterwards is ignored until it is released and pressed again.

Test Plan (DELAY_CYCLES=8, RATE_CYCLES=4, CNT_W=4):
- Short press: rst low for 3 cycles, btn_level rises, held 3 cycles, then falls. Required: press_pulse=step_pulse=1 for one cycle (cycle P); release_pulse for one cycle after the fall; held stays 0; repeat_count=0.
- Long hold: btn_level high for 30 cycles. Required: step_pulse at P, P+8, P+12, P+16, P+20, P+24, P+28; held=1 from P+8; repeat_count=6 at release; one release_pulse; held=0 afterwards.
- Release coincides with a terminal count: btn_level falls so that it is sampled low on the edge where counter==3 in REPEAT. Required: release_pulse=1 and step_pulse=0 in that cycle; repeat_count does not increment.
- enable control:
  - enable dropped to 0 while in REPEAT: held=0 next cycle, no release_pulse.
  - enable raised to 1 while the button is still held: no pulses.
  - Release then re-press: press_pulse fires again.
- Saturation: RATE_CYCLES=2, button held for 600 cycles. Required: repeat_count reaches 255 and stays there; step_pulse keeps firing every 2 cycles.
- Reset during hold: rst=0 for one cycle in REPEAT with btn_level=1. Required: all outputs 0 next cycle; no press_pulse while still held; release and re-press gives press_pulse.
